fc_ctrl: RTL and testbench

FC_CTRL -- requirements
Module: fc_ctrl

---
 rtl/fc_pkg.sv | 19 +
 rtl/fc_argmax.sv | 51 +++++
 rtl/fc_ctrl.sv | 130 +++++++++++++
 tb/tb_fc_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared constants and FSM encoding for the fully-connected
// layer controller and its argmax helper.
package fc_pkg;

    localparam int N_CLASS    = 10;
    localparam int SCORE_W    = 32;
    localparam int N_FEAT_DEF = 845;
    localparam int SEL_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_SCAN,
        ST_DONE
    } fc_state_e;

endpackage

// File: rtl/fc_argmax.sv
// Sequential running-max over the class scores; the first sample after
// clear always wins, later ones only on a strictly greater signed score.
module fc_argmax
    import fc_pkg::*;
#(
    parameter int SCORE_W = fc_pkg::SCORE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      step,
    input  logic [SEL_W-1:0]          idx,
    input  logic signed [SCORE_W-1:0] score,
    output logic [SEL_W-1:0]          best_idx_nxt
);

    logic signed [SCORE_W-1:0] max_q, max_d;
    logic [SEL_W-1:0]          idx_q, idx_d;
    logic                      first_q, first_d;
    logic                      take;

    always_comb begin
        max_d   = max_q;
        idx_d   = idx_q;
        first_d = first_q;
        take    = first_q || (score > max_q);
        if (clear) begin
            first_d = 1'b1;
        end else if (step) begin
            first_d = 1'b0;
            if (take) begin
                max_d = score;
                idx_d = idx;
            end
        end
        best_idx_nxt = (step && take) ? idx : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q   <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
        end else begin
            max_q   <= max_d;
            idx_q   <= idx_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/fc_ctrl.sv
// Frame controller: streams features against the weight ROM, then scans
// the class scores and reports the argmax digit.
module fc_ctrl
    import fc_pkg::*;
#(
    parameter int N_FEAT  = fc_pkg::N_FEAT_DEF,
    parameter int N_CLASS = fc_pkg::N_CLASS,
    parameter int ROM_LAT = 1,
    parameter int SCORE_W = fc_pkg::SCORE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      feat_valid,
    output logic                      feat_ready,
    output logic [$clog2(N_FEAT)-1:0] rom_addr,
    output logic                      mac_clr,
    output logic                      mac_en,
    output logic [SEL_W-1:0]          score_sel,
    input  logic signed [SCORE_W-1:0] score_in,
    output logic [SEL_W-1:0]          result_digit,
    output logic                      result_valid,
    output logic                      busy
);

    localparam int AW = $clog2(N_FEAT);

    fc_state_e        state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] digit_q, digit_d;
    logic [ROM_LAT-1:0] acc_q, acc_d;
    logic             accept;
    logic             scan_step;
    logic [SEL_W-1:0] best_idx_nxt;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        digit_d   = digit_q;
        accept    = 1'b0;
        scan_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                end
            end
            ST_CLEAR: state_d = ST_ACCUM;
            ST_ACCUM: begin
                accept = feat_valid;
                if (feat_valid) begin
                    if (addr_q == AW'(N_FEAT - 1)) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == SEL_W'(ROM_LAT - 1)) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SCAN: begin
                scan_step = 1'b1;
                if (cnt_q == SEL_W'(N_CLASS - 1)) begin
                    state_d = ST_DONE;
                    digit_d = best_idx_nxt;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Accept strobe delayed to line up with the ROM read data.
    always_comb begin
        acc_d[0] = accept;
        for (int i = 1; i < ROM_LAT; i++) begin
            acc_d[i] = acc_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            digit_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            acc_q   <= acc_d;
        end
    end

    fc_argmax #(
        .SCORE_W(SCORE_W)
    ) u_argmax (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (state_q == ST_CLEAR),
        .step        (scan_step),
        .idx         (cnt_q),
        .score       (score_in),
        .best_idx_nxt(best_idx_nxt)
    );

    assign feat_ready   = (state_q == ST_ACCUM);
    assign rom_addr     = addr_q;
    assign mac_clr      = (state_q == ST_CLEAR);
    assign mac_en       = acc_q[ROM_LAT-1];
    assign score_sel    = (state_q == ST_SCAN) ? cnt_q : '0;
    assign result_digit = digit_q;
    assign result_valid = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fc_ctrl.sv
// Bench for fc_ctrl: two instances (ROM_LAT 1 and 2) share stimulus;
// mac_en timing is scoreboarded from the accepts the bench drives.
module tb_fc_ctrl;

    localparam int NF = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic feat_valid = 1'b0;

    logic fr1, clr1, en1, rv1, busy1;
    logic fr2, clr2, en2, rv2, busy2;
    logic [1:0] addr1, addr2;
    logic [3:0] sel1, sel2, dig1, dig2;
    logic signed [31:0] sc1, sc2;
    logic signed [31:0] scores [10];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int q1[$];
    int q2[$];

    always #5 clk = ~clk;

    assign sc1 = (sel1 < 4'd10) ? scores[sel1] : 32'sd0;
    assign sc2 = (sel2 < 4'd10) ? scores[sel2] : 32'sd0;

    fc_ctrl #(.N_FEAT(NF), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .feat_valid(feat_valid), .feat_ready(fr1),
        .rom_addr(addr1), .mac_clr(clr1), .mac_en(en1),
        .score_sel(sel1), .score_in(sc1),
        .result_digit(dig1), .result_valid(rv1), .busy(busy1)
    );

    fc_ctrl #(.N_FEAT(NF), .ROM_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .feat_valid(feat_valid), .feat_ready(fr2),
        .rom_addr(addr2), .mac_clr(clr2), .mac_en(en2),
        .score_sel(sel2), .score_in(sc2),
        .result_digit(dig2), .result_valid(rv2), .busy(busy2)
    );

    function automatic logic [3:0] ref_argmax();
        logic [3:0] best = 4'd0;
        logic signed [31:0] m = scores[0];
        for (int i = 1; i < 10; i++) begin
            if (scores[i] > m) begin
                m = scores[i];
                best = 4'(i);
            end
        end
        return best;
    endfunction

    task automatic set_scores(input int kind);
        for (int i = 0; i < 10; i++) scores[i] = -32'sd1;
        if (kind == 0) begin
            scores[0] = 5; scores[1] = -3; scores[2] = 9; scores[3] = 9;
            for (int i = 4; i < 10; i++) scores[i] = 0;
        end else if (kind == 2) begin
            for (int i = 0; i < 10; i++) scores[i] = $signed($urandom_range(2000)) - 1000;
            scores[7] = 32'sd5000;
        end
    endtask

    // mode 0: continuous feat_valid; mode 1: toggled 1,0,1,0
    task automatic run_frame(input int mode, input int s_a, input int s_b,
                             input logic [3:0] exp_dig);
        int stalls = 0;
        int rv1c = -1;
        int rv2c = -1;
        int rv1n = 0;
        int rv2n = 0;
        int nacc = 0;
        int due;
        logic fv;
        q1.delete();
        q2.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            n_cmp++;
            if (clr1 !== (cyc == 1)) begin
                n_bad++; $display("FAIL mac_clr1 cyc %0d got %b", cyc, clr1);
            end
            n_cmp++;
            if (clr2 !== (cyc == 1)) begin
                n_bad++; $display("FAIL mac_clr2 cyc %0d got %b", cyc, clr2);
            end
            if (en1 === 1'b1) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_bad++; $display("FAIL mac_en1 spurious cyc %0d", cyc);
                end else begin
                    due = q1.pop_front();
                    if (due != cyc) begin
                        n_bad++; $display("FAIL mac_en1 cyc %0d want %0d", cyc, due);
                    end
                end
            end
            if (en2 === 1'b1) begin
                n_cmp++;
                if (q2.size() == 0) begin
                    n_bad++; $display("FAIL mac_en2 spurious cyc %0d", cyc);
                end else begin
                    due = q2.pop_front();
                    if (due != cyc) begin
                        n_bad++; $display("FAIL mac_en2 cyc %0d want %0d", cyc, due);
                    end
                end
            end
            if (rv1 === 1'b1) begin
                rv1n++;
                if (rv1n == 1) rv1c = cyc;
                n_cmp++;
                if (dig1 !== exp_dig || addr1 !== 2'(NF - 1) || fr1 !== 1'b0 || busy1 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL done1 dig %0d addr %0d fr %b busy %b want dig %0d addr %0d",
                             dig1, addr1, fr1, busy1, exp_dig, NF - 1);
                end
            end
            if (rv2 === 1'b1) begin
                rv2n++;
                if (rv2n == 1) rv2c = cyc;
                n_cmp++;
                if (dig2 !== exp_dig || addr2 !== 2'(NF - 1)) begin
                    n_bad++;
                    $display("FAIL done2 dig %0d addr %0d want %0d", dig2, addr2, exp_dig);
                end
            end
            fv = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            feat_valid = fv;
            start = (cyc == s_a || cyc == s_b);
            if (fr1 === 1'b1) begin
                if (fv) begin
                    n_cmp++;
                    if (addr1 !== 2'(nacc) || addr2 !== 2'(nacc)) begin
                        n_bad++;
                        $display("FAIL rom_addr got %0d/%0d want %0d", addr1, addr2, nacc);
                    end
                    nacc++;
                    q1.push_back(cyc + 1);
                    q2.push_back(cyc + 2);
                end else begin
                    stalls++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (rv1c > 0 && rv2c > 0 && cyc > rv2c + 3) break;
        end
        feat_valid = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (rv1c != 17 + stalls || rv1n != 1) begin
            n_bad++; $display("FAIL latency1 got %0d x%0d want %0d x1", rv1c, rv1n, 17 + stalls);
        end
        n_cmp++;
        if (rv2c != 18 + stalls || rv2n != 1) begin
            n_bad++; $display("FAIL latency2 got %0d x%0d want %0d x1", rv2c, rv2n, 18 + stalls);
        end
        n_cmp++;
        if (nacc != NF || q1.size() != 0 || q2.size() != 0) begin
            n_bad++;
            $display("FAIL accepts got %0d pend %0d/%0d want %0d 0/0", nacc, q1.size(), q2.size(), NF);
        end
        n_cmp++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0 || dig1 !== exp_dig || dig2 !== exp_dig) begin
            n_bad++;
            $display("FAIL after_frame busy %b/%b dig %0d/%0d want 0/0 %0d", busy1, busy2, dig1, dig2, exp_dig);
        end
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if ({fr1, clr1, en1, rv1, busy1, addr1, sel1, dig1} !== '0) begin
            n_bad++;
            $display("FAIL %s dut1 fr%b clr%b en%b rv%b busy%b addr%0d sel%0d dig%0d want all 0",
                     tag, fr1, clr1, en1, rv1, busy1, addr1, sel1, dig1);
        end
        n_cmp++;
        if ({fr2, clr2, en2, rv2, busy2, addr2, sel2, dig2} !== '0) begin
            n_bad++;
            $display("FAIL %s dut2 fr%b clr%b en%b rv%b busy%b addr%0d sel%0d dig%0d want all 0",
                     tag, fr2, clr2, en2, rv2, busy2, addr2, sel2, dig2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("post_reset");
    endtask

    task automatic test_basic();
        set_scores(0);
        run_frame(0, -1, -1, 4'd2);
    endtask

    task automatic test_all_neg();
        set_scores(1);
        run_frame(0, -1, -1, 4'd0);
    endtask

    task automatic test_random_scores();
        set_scores(2);
        run_frame(0, -1, -1, ref_argmax());
    endtask

    task automatic test_stall();
        set_scores(0);
        run_frame(1, -1, -1, 4'd2);
    endtask

    task automatic test_start_ignore();
        set_scores(2);
        scores[4] = 32'sd6000;
        run_frame(0, 3, 10, ref_argmax());
    endtask

    task automatic test_reset_mid();
        int k = 0;
        set_scores(0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feat_valid = 1'b1;
        while (addr1 !== 2'd2 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_cmp++;
        if (k >= 20 || fr1 !== 1'b1) begin
            n_bad++; $display("FAIL reach_addr2 waited %0d fr %b want addr 2 in ACCUM", k, fr1);
        end
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        feat_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rv1 !== 1'b0 || rv2 !== 1'b0 || busy1 !== 1'b0) begin
                n_bad++; $display("FAIL abandoned rv %b/%b busy %b want 0", rv1, rv2, busy1);
            end
        end
        set_scores(1);
        scores[9] = 32'sd3;
        run_frame(0, -1, -1, 4'd9);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_neg();
        test_random_scores();
        test_stall();
        test_start_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
